split_target_q: RTL and testbench

Parametrised split-capable bus target with an in-order queue of outstanding split reads. A read is acknowledged with a split response and its data captured immediately. The target then re-requests the bus via `split_req`/`split_grant` to return each result after a programmable latency. It sits on the target side of the bus interconnect as a successor to the single-outstanding split target, adding configurable data width, memory depth, queue depth and a `last_write` status port for board LEDs.

---
 rtl/split_target_q_pkg.sv | 22 ++
 rtl/split_target_q_fifo.sv | 62 ++++++
 rtl/split_target_q.sv | 183 ++++++++++++++++++
 tb/tb_split_target_q.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/split_target_q_pkg.sv
// -----------------------------------------------------------------------------
// split_target_q_pkg
// Shared types and constants for the split_target_q bus target:
//   split_q_state_t : return-path FSM states (IDLE, WAIT, REQ, RESP)
//   RW_WRITE/RW_READ: encoding of the target_rw request bit
//   DROP_CNT_MAX    : saturation value of the refused-request counter
// -----------------------------------------------------------------------------
package split_target_q_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      REQ  = 2'd2,
      RESP = 2'd3
   } split_q_state_t;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   localparam int unsigned DROP_CNT_MAX = 255;

endpackage

// File: rtl/split_target_q_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding read data captured at acceptance until returned.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (flushes pointers)
//   push_i, wdata_i : enqueue; caller guarantees !full_o (or a same-cycle pop)
//   pop_i           : dequeue head; caller guarantees !empty_o
//   rdata_o         : current head (combinational)
//   full_o, empty_o : status
//   level_o         : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push_i && !pop_i)      level_q <= level_q + 1'b1;
         else if (pop_i && !push_i) level_q <= level_q - 1'b1;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

endmodule

// File: rtl/split_target_q.sv
// -----------------------------------------------------------------------------
// split_target_q
// Split-capable bus target. Writes complete with target_ack the next cycle.
// Reads are answered with target_split_ack; their data is captured into an
// in-order queue at acceptance and returned later via split_req/split_grant,
// READ_LATENCY cycles after the entry reaches the head.
//
// Optional feature macro: SPLIT_TARGET_Q_DROP_CNT_EN
//   defined   -> drop_count counts cycles with a request while not ready
//                (saturating at 255)
//   undefined -> drop_count tied to 0
//
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   target_addr_in(_valid)          : request address / present
//   target_data_in(_valid)          : write data / present
//   target_rw                       : 1 write, 0 read
//   split_grant                     : bus grants the return slot (REQ only)
//   target_ready                    : queue has room
//   target_ack                      : write done and/or read data returned
//   target_split_ack                : read deferred
//   split_req                       : asking the bus for a return slot
//   target_data_out(_valid)         : returned read data
//   split_target_last_write         : last accepted write data
//   drop_count                      : refused-request counter
// -----------------------------------------------------------------------------
module split_target_q
   import split_target_q_pkg::*;
#(
   parameter int DATA_WIDTH         = 8,
   parameter int ADDR_WIDTH         = 16,
   parameter int INTERNAL_ADDR_BITS = 12,
   parameter int READ_LATENCY       = 4,
   parameter int QUEUE_DEPTH        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] target_addr_in,
   input  logic                  target_addr_in_valid,
   input  logic [DATA_WIDTH-1:0] target_data_in,
   input  logic                  target_data_in_valid,
   input  logic                  target_rw,
   input  logic                  split_grant,
   output logic                  target_ready,
   output logic                  target_ack,
   output logic                  target_split_ack,
   output logic                  split_req,
   output logic [DATA_WIDTH-1:0] target_data_out,
   output logic                  target_data_out_valid,
   output logic [DATA_WIDTH-1:0] split_target_last_write,
   output logic [7:0]            drop_count
);

   localparam int LVL_W = $clog2(QUEUE_DEPTH + 1);
   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD =
      (READ_LATENCY > 0) ? LAT_W'(READ_LATENCY - 1) : '0;
   // With zero latency the WAIT state is skipped entirely.
   localparam split_q_state_t ENTRY_ST = (READ_LATENCY == 0) ? REQ : WAIT;

   logic [DATA_WIDTH-1:0] mem_q [2**INTERNAL_ADDR_BITS];
   logic [INTERNAL_ADDR_BITS-1:0] idx;

   split_q_state_t        state_q, state_d;
   logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
   logic                  wr_ack_q, split_ack_q;
   logic [DATA_WIDTH-1:0] last_wr_q;

   logic                  wr_acc, rd_acc, pop;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  fifo_full, fifo_empty;
   logic [LVL_W-1:0]      fifo_level;

   assign idx = target_addr_in[INTERNAL_ADDR_BITS-1:0];

   generate
      if (ADDR_WIDTH > INTERNAL_ADDR_BITS) begin : g_upper
         logic unused_addr_hi;
         assign unused_addr_hi = ^target_addr_in[ADDR_WIDTH-1:INTERNAL_ADDR_BITS];
      end
   endgenerate

   assign target_ready = !fifo_full;
   assign wr_acc = target_addr_in_valid && target_data_in_valid &&
                   (target_rw == RW_WRITE) && target_ready;
   assign rd_acc = target_addr_in_valid && (target_rw == RW_READ) && target_ready;

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[idx] <= target_data_in;
   end

   // Read data is captured here, so later writes cannot disturb queued results.
   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (QUEUE_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rd_acc),
      .wdata_i (mem_q[idx]),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lat_cnt_q   <= '0;
         wr_ack_q    <= 1'b0;
         split_ack_q <= 1'b0;
         last_wr_q   <= '0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         wr_ack_q    <= wr_acc;
         split_ack_q <= rd_acc;
         if (wr_acc) last_wr_q <= target_data_in;
      end
   end

   // A read accepted this cycle counts as queue content so that with zero
   // latency split_req rises together with target_split_ack.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_acc || !fifo_empty) begin
               state_d   = ENTRY_ST;
               lat_cnt_d = LAT_LOAD;
            end
         end
         WAIT: begin
            if (lat_cnt_q == '0) state_d   = REQ;
            else                 lat_cnt_d = lat_cnt_q - 1'b1;
         end
         REQ: begin
            if (split_grant) state_d = RESP;
         end
         RESP: begin
            pop = 1'b1;
            if (rd_acc || (fifo_level > LVL_W'(1))) begin
               state_d   = ENTRY_ST;
               lat_cnt_d = LAT_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign split_req               = (state_q == REQ);
   assign target_data_out_valid   = (state_q == RESP);
   assign target_data_out         = (state_q == RESP) ? fifo_rdata : '0;
   // Write ack and read-return ack share one pulse; data_out_valid tells them apart.
   assign target_ack              = wr_ack_q || (state_q == RESP);
   assign target_split_ack        = split_ack_q;
   assign split_target_last_write = last_wr_q;

`ifdef SPLIT_TARGET_Q_DROP_CNT_EN
   logic [7:0] drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= '0;
      end else if (target_addr_in_valid && !target_ready &&
                   (drop_q != 8'(DROP_CNT_MAX))) begin
         drop_q <= drop_q + 1'b1;
      end
   end

   assign drop_count = drop_q;
`else
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_split_target_q.sv
// -----------------------------------------------------------------------------
// tb_split_target_q
// Directed bench: main instance with READ_LATENCY=4, QUEUE_DEPTH=4, and a
// second instance with READ_LATENCY=0 sharing the same stimulus.
// -----------------------------------------------------------------------------
module tb_split_target_q;

`ifdef SPLIT_TARGET_Q_DROP_CNT_EN
   localparam int EXP_DROP = 1;
`else
   localparam int EXP_DROP = 0;
`endif

   logic        clk = 1'b0;
   logic        rst, addr_v, data_v, rw, grant;
   logic [15:0] addr;
   logic [7:0]  din;

   logic       ready, ack, sack, sreq, dov;
   logic [7:0] dout, lastw, drop;
   logic       ready0, ack0, sack0, sreq0, dov0;
   logic [7:0] dout0, lastw0, drop0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   split_target_q #(.READ_LATENCY(4), .QUEUE_DEPTH(4)) u_dut (
      .clk(clk), .rst(rst),
      .target_addr_in(addr), .target_addr_in_valid(addr_v),
      .target_data_in(din), .target_data_in_valid(data_v),
      .target_rw(rw), .split_grant(grant),
      .target_ready(ready), .target_ack(ack), .target_split_ack(sack),
      .split_req(sreq), .target_data_out(dout), .target_data_out_valid(dov),
      .split_target_last_write(lastw), .drop_count(drop)
   );

   split_target_q #(.READ_LATENCY(0), .QUEUE_DEPTH(4)) u_dut0 (
      .clk(clk), .rst(rst),
      .target_addr_in(addr), .target_addr_in_valid(addr_v),
      .target_data_in(din), .target_data_in_valid(data_v),
      .target_rw(rw), .split_grant(grant),
      .target_ready(ready0), .target_ack(ack0), .target_split_ack(sack0),
      .split_req(sreq0), .target_data_out(dout0), .target_data_out_valid(dov0),
      .split_target_last_write(lastw0), .drop_count(drop0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; din = d; addr_v = 1'b1; data_v = 1'b1; rw = 1'b1;
      step();
      addr_v = 1'b0; data_v = 1'b0; rw = 1'b0;
      chk("wr_ack", ack, 1);
      chk("wr_last", lastw, d);
      step();
      chk("wr_ack_pulse", ack, 0);
   endtask

   task automatic wait_dov(input string tag);
      int n;
      n = 0;
      while (!dov && n < 60) begin
         step();
         n++;
      end
      chk(tag, dov, 1);
   endtask

   task automatic rd_get(input logic [15:0] a, output logic [7:0] d);
      addr = a; addr_v = 1'b1; rw = 1'b0;
      step();
      addr_v = 1'b0;
      chk("rd_sack", sack, 1);
      grant = 1'b1;
      wait_dov("rd_valid");
      d = dout;
      grant = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0] d;
      int last_c, n;
      logic seen;

      rst = 1'b1; addr_v = 0; data_v = 0; rw = 0; grant = 0; addr = '0; din = '0;
      step(); step();
      chk("rst_ready", ready, 1);
      chk("rst_ack", ack, 0);
      chk("rst_sreq", sreq, 0);
      chk("rst_dov", dov, 0);
      chk("rst_drop", drop, 0);
      chk("rst_last", lastw, 0);
      rst = 1'b0;
      step();

      // Write then read, latency 4, grant raised early (stray in WAIT).
      wr(16'h0123, 8'hA5);
      addr = 16'h0123; addr_v = 1'b1; rw = 1'b0;
      step();                                   // k+1
      addr_v = 1'b0;
      chk("t1_sack", sack, 1);
      chk("t1_req_early", sreq, 0);
      step();                                   // k+2
      chk("t1_sack_pulse", sack, 0);
      step(); step();                           // k+4
      chk("t1_req_k4", sreq, 0);
      grant = 1'b1;
      step();                                   // k+5
      chk("t1_req_k5", sreq, 1);
      chk("t1_nodov", dov, 0);
      step();                                   // RESP
      chk("t1_dov", dov, 1);
      chk("t1_data", dout, 8'hA5);
      chk("t1_ack", ack, 1);
      chk("t1_req_low", sreq, 0);
      grant = 1'b0;
      step();
      chk("t1_dov_pulse", dov, 0);
      chk("t1_ack_pulse", ack, 0);

      // Queue fill with grant held low, then in-order drain.
      for (int i = 0; i < 4; i++) wr(16'h0100 + 16'(i), 8'h30 + 8'(i));
      for (int i = 0; i < 5; i++) begin
         addr = 16'h0100 + 16'(i); addr_v = 1'b1; rw = 1'b0;
         step();
         chk("t2_sack", sack, (i < 4));
         chk("t2_ready", ready, (i < 3));
      end
      addr_v = 1'b0;
      chk("t2_drop", drop, EXP_DROP);
      grant = 1'b1;
      last_c = 0;
      for (int i = 0; i < 4; i++) begin
         wait_dov("t2_valid");
         chk("t2_data", dout, 8'h30 + 8'(i));
         if (i > 0) chk("t2_gap", cyc - last_c, 6);
         last_c = cyc;
         step();
      end
      grant = 1'b0;
      chk("t2_ready_after", ready, 1);
      step();

      // Read-then-write hazard.
      wr(16'h0010, 8'h11);
      addr = 16'h0010; addr_v = 1'b1; rw = 1'b0;
      step();
      chk("t3_sack", sack, 1);
      din = 8'h22; data_v = 1'b1; rw = 1'b1;
      step();
      addr_v = 1'b0; data_v = 1'b0; rw = 1'b0;
      chk("t3_wr_ack", ack, 1);
      grant = 1'b1;
      wait_dov("t3_valid");
      chk("t3_old", dout, 8'h11);
      grant = 1'b0;
      step();
      rd_get(16'h0010, d);
      chk("t3_new", d, 8'h22);

      // Stray grants in IDLE and WAIT.
      grant = 1'b1;
      step();
      grant = 1'b0;
      chk("t6_idle_dov", dov, 0);
      chk("t6_idle_req", sreq, 0);
      addr = 16'h0101; addr_v = 1'b1; rw = 1'b0;
      step();                                   // k+1
      addr_v = 1'b0;
      grant = 1'b1;
      step();                                   // k+2
      grant = 1'b0;
      chk("t6_wait_dov", dov, 0);
      step(); step();                           // k+4
      chk("t6_req_k4", sreq, 0);
      step();                                   // k+5
      chk("t6_req_k5", sreq, 1);
      grant = 1'b1;
      wait_dov("t6_valid");
      chk("t6_data", dout, 8'h31);
      grant = 1'b0;
      step();

      // Reset while in REQ with two entries queued.
      addr = 16'h0100; addr_v = 1'b1; rw = 1'b0;
      step();
      addr = 16'h0101;
      step();
      addr_v = 1'b0;
      n = 0;
      while (!sreq && n < 60) begin step(); n++; end
      chk("t5_in_req", sreq, 1);
      rst = 1'b1;
      step();
      chk("t5_ack", ack, 0);
      chk("t5_sack", sack, 0);
      chk("t5_sreq", sreq, 0);
      chk("t5_dov", dov, 0);
      chk("t5_dout", dout, 0);
      chk("t5_last", lastw, 0);
      chk("t5_drop", drop, 0);
      chk("t5_ready", ready, 1);
      rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         step();
         if (sreq) seen = 1'b1;
      end
      chk("t5_no_req", seen, 0);

      // Zero latency instance.
      wr(16'h0200, 8'h5A);
      addr = 16'h0200; addr_v = 1'b1; rw = 1'b0;
      step();
      addr_v = 1'b0;
      chk("t4_sack", sack0, 1);
      chk("t4_req", sreq0, 1);
      grant = 1'b1;
      step();
      grant = 1'b0;
      chk("t4_dov", dov0, 1);
      chk("t4_data", dout0, 8'h5A);
      chk("t4_ack", ack0, 1);
      chk("t4_req_low", sreq0, 0);
      step();
      chk("t4_dov_pulse", dov0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
